// File: rtl/abs_pipe_pkg.sv
// ============================================================================
// Module      : abs_pipe_pkg
// Description : Shared constants and helper functions for the abs_pipe unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package abs_pipe_pkg;

    localparam int MAX_WIDTH  = 1024;
    localparam int MIN_WIDTH  = 2;
    localparam int MIN_STAGES = 1;

    // Most-negative two's-complement pattern: 1 followed by width-1 zeros.
    function automatic logic [MAX_WIDTH-1:0] most_neg(input int width);
        return MAX_WIDTH'(1) << (width - 1);
    endfunction

    // Largest positive value: 0 followed by width-1 ones.
    function automatic logic [MAX_WIDTH-1:0] pos_max(input int width);
        return most_neg(width) - MAX_WIDTH'(1);
    endfunction

    function automatic bit params_ok(input int width, input int stages);
        return (width >= MIN_WIDTH) && (stages >= MIN_STAGES);
    endfunction

endpackage

`default_nettype wire

// File: rtl/padder_n.sv
// ============================================================================
// Module      : padder_n
// Description : WIDTH-bit Kogge-Stone parallel-prefix adder (combinational).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module padder_n #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic [WIDTH-1:0] S,
    output logic             Cout
);

    localparam int c_LEVELS = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [WIDTH-1:0] w_p;
    logic [WIDTH-1:0] w_gv;
    logic [WIDTH-1:0] w_pv;
    logic [WIDTH-1:0] w_gn;
    logic [WIDTH-1:0] w_pn;
    logic [WIDTH-1:0] w_c;

    assign w_p = A ^ B;

    // Carry-in is folded into bit 0's generate so the prefix tree yields
    // true carries directly.
    always_comb begin
        w_gv    = A & B;
        w_pv    = w_p;
        w_gv[0] = w_gv[0] | (w_p[0] & Cin);
        w_gn    = w_gv;
        w_pn    = w_pv;
        for (int l = 0; l < c_LEVELS; l++) begin
            w_gn = w_gv;
            w_pn = w_pv;
            for (int i = (1 << l); i < WIDTH; i++) begin
                w_gn[i] = w_gv[i] | (w_pv[i] & w_gv[i - (1 << l)]);
                w_pn[i] = w_pv[i] & w_pv[i - (1 << l)];
            end
            w_gv = w_gn;
            w_pv = w_pn;
        end
    end

    assign w_c  = {w_gv[WIDTH-2:0], Cin};
    assign S    = w_p ^ w_c;
    assign Cout = w_gv[WIDTH-1];

endmodule

`default_nettype wire

// File: rtl/abs_pipe.sv
// ============================================================================
// Module      : abs_pipe
// Description : Pipelined two's-complement absolute value with valid/ready
//               flow control and overflow flag. ABS_PIPE_SAT_EN saturates
//               the most-negative input to +max instead of wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module abs_pipe
    import abs_pipe_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_ovf
);

    localparam logic [WIDTH-1:0] c_MOST_NEG = WIDTH'(most_neg(WIDTH));

    if (!params_ok(WIDTH, STAGES)) begin : g_param_check
        $error("abs_pipe: WIDTH must be >= 2 and STAGES >= 1");
    end

    logic             w_s;
    logic [WIDTH-1:0] w_x;
    logic             w_in_ovf;
    logic [WIDTH-1:0] w_add_a;
    logic             w_add_cin;
    logic [WIDTH-1:0] w_sum;
    logic             w_unused_cout;
    logic [WIDTH-1:0] w_s1_data;
    logic [STAGES:1]  w_load;
    logic [STAGES:1]  r_v;
    logic [STAGES:1]  r_o;
    logic [WIDTH-1:0] r_d [1:STAGES];

    assign w_s      = in_data[WIDTH-1];
    assign w_x      = in_data ^ {WIDTH{w_s}};
    assign w_in_ovf = (in_data == c_MOST_NEG);

    padder_n #(
        .WIDTH (WIDTH)
    ) u_padder (
        .A    (w_add_a),
        .B    ({WIDTH{1'b0}}),
        .Cin  (w_add_cin),
        .S    (w_sum),
        .Cout (w_unused_cout)
    );

    if (STAGES == 1) begin : g_add_pre
        assign w_add_a   = w_x;
        assign w_add_cin = w_s;
        assign w_s1_data = w_sum;
    end else begin : g_add_post
        logic r_s1;
        always_ff @(posedge clk) begin
            if (w_load[1] && in_valid) begin
                r_s1 <= w_s;
            end
        end
        assign w_add_a   = r_d[1];
        assign w_add_cin = r_s1;
        assign w_s1_data = w_x;
    end

    // A stage can load when it or any stage downstream of it has a hole,
    // or when the consumer drains the last stage this cycle.
    for (genvar k = 1; k <= STAGES; k++) begin : g_load
        assign w_load[k] = out_ready | ~(&r_v[STAGES:k]);
    end

    for (genvar k = 1; k <= STAGES; k++) begin : g_stage
        if (k == 1) begin : g_first
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_v[1] <= 1'b0;
                end else if (w_load[1]) begin
                    r_v[1] <= in_valid;
                end
            end
            always_ff @(posedge clk) begin
                if (w_load[1] && in_valid) begin
                    r_d[1] <= w_s1_data;
                    r_o[1] <= w_in_ovf;
                end
            end
        end else begin : g_next
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_v[k] <= 1'b0;
                end else if (w_load[k]) begin
                    r_v[k] <= r_v[k-1];
                end
            end
            always_ff @(posedge clk) begin
                if (w_load[k] && r_v[k-1]) begin
                    r_d[k] <= (k == 2) ? w_sum : r_d[k-1];
                    r_o[k] <= r_o[k-1];
                end
            end
        end
    end

    assign in_ready  = w_load[1];
    assign out_valid = r_v[STAGES];
    assign out_ovf   = r_o[STAGES];

`ifdef ABS_PIPE_SAT_EN
    localparam logic [WIDTH-1:0] c_POS_MAX = WIDTH'(pos_max(WIDTH));
    assign out_data = r_o[STAGES] ? c_POS_MAX : r_d[STAGES];
`else
    assign out_data = r_d[STAGES];
`endif

endmodule

`default_nettype wire

// File: tb/tb_abs_pipe.sv
// ============================================================================
// Module      : tb_abs_pipe
// Description : Self-checking bench for abs_pipe (table vectors, scoreboard,
//               back-pressure, mid-stream reset, parameter sweep).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_abs_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

`ifdef ABS_PIPE_SAT_EN
    localparam logic [15:0] c_OVF16 = 16'h7FFF;
`else
    localparam logic [15:0] c_OVF16 = 16'h8000;
`endif

    // ---------------- main DUT: WIDTH=16, STAGES=2 ----------------
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_ovf;

    abs_pipe #(
        .WIDTH  (16),
        .STAGES (2)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ovf   (out_ovf)
    );

    typedef struct {
        logic [15:0] d;
        logic        o;
        int          acc;
    } rec_t;

    typedef struct {
        logic [15:0] din;
        logic [15:0] ed;
        logic        eo;
    } vec_t;

    rec_t sb[$];
    logic chk_lat = 1'b0;

    function automatic rec_t abs16(input logic [15:0] x);
        rec_t r;
        r.o   = (x == 16'h8000);
        r.d   = x[15] ? (~x + 16'd1) : x;
        if (r.o) r.d = c_OVF16;
        r.acc = 0;
        return r;
    endfunction

    task automatic push_exp(input logic [15:0] ed, input logic eo);
        rec_t r;
        r.d   = ed;
        r.o   = eo;
        r.acc = cyc;
        sb.push_back(r);
    endtask

    task automatic send(input logic [15:0] d, input logic [15:0] ed, input logic eo);
        bit ok;
        ok       = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            ok = in_ready;
            if (ok) push_exp(ed, eo);
            @(posedge clk);
            #1;
            if (ok) break;
        end
        in_valid = 1'b0;
        check("send_accept", {63'd0, ok}, 64'd1);
    endtask

    task automatic wait_drain();
        for (int t = 0; t < 50 && sb.size() != 0; t++) @(posedge clk);
        #1;
        check("drain_empty", sb.size(), 0);
    endtask

    always @(negedge clk) begin
        rec_t r;
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("spurious_out", {63'd0, out_valid}, 64'd0);
            end else begin
                r = sb.pop_front();
                check("out_data", out_data, r.d);
                check("out_ovf", out_ovf, r.o);
                if (chk_lat) check("latency", cyc - r.acc, 2);
            end
        end
    end

    // ---------------- parameter sweep ----------------
    for (genvar gi = 0; gi < 3; gi++) begin : g_sweep
        localparam int W = (gi == 0) ? 2 : (gi == 1) ? 8 : 33;
        localparam int S = (gi == 0) ? 4 : (gi == 1) ? 1 : 4;
        localparam logic [W-1:0] c_MN = {1'b1, {(W-1){1'b0}}};

        logic         srst, iv, ir, ov, ordy, oo, lat_chk, done;
        logic [W-1:0] id, od;
        logic [W-1:0] qd[$];
        logic         qo[$];
        int           qa[$];

        abs_pipe #(
            .WIDTH  (W),
            .STAGES (S)
        ) u_sdut (
            .clk       (clk),
            .rst       (srst),
            .in_valid  (iv),
            .in_ready  (ir),
            .in_data   (id),
            .out_valid (ov),
            .out_ready (ordy),
            .out_data  (od),
            .out_ovf   (oo)
        );

        function automatic logic [W-1:0] ref_d(input logic [W-1:0] x);
            logic [W-1:0] r;
            r = x[W-1] ? (~x + W'(1)) : x;
`ifdef ABS_PIPE_SAT_EN
            if (x == c_MN) r = ~c_MN;
`endif
            return r;
        endfunction

        always @(negedge clk) begin
            logic [W-1:0] ed;
            logic         eo;
            int           ea;
            if (!srst) begin
                if (ov && ordy) begin
                    if (qd.size() == 0) begin
                        check($sformatf("w%0d_spurious", W), {63'd0, ov}, 64'd0);
                    end else begin
                        ed = qd.pop_front();
                        eo = qo.pop_front();
                        ea = qa.pop_front();
                        check($sformatf("w%0d_data", W), 64'(od), 64'(ed));
                        check($sformatf("w%0d_ovf", W), {63'd0, oo}, {63'd0, eo});
                        if (lat_chk) check($sformatf("w%0d_latency", W), cyc - ea, S);
                    end
                end
                if (iv && ir) begin
                    qd.push_back(ref_d(id));
                    qo.push_back(id == c_MN);
                    qa.push_back(cyc);
                end
            end
        end

        initial begin
            srst = 1'b1; iv = 1'b0; ordy = 1'b0; id = '0; lat_chk = 1'b0; done = 1'b0;
            repeat (3) @(posedge clk);
            #1 srst = 1'b0;
            ordy    = 1'b1;
            lat_chk = 1'b1;
            for (int i = 0; i < 200; i++) begin
                iv = ($urandom_range(0, 3) != 0);
                id = (i % 7 == 3) ? c_MN : W'({$urandom(), $urandom()});
                @(posedge clk);
                #1;
            end
            iv = 1'b0;
            repeat (S + 3) @(posedge clk);
            #1 lat_chk = 1'b0;
            for (int i = 0; i < 300; i++) begin
                iv   = ($urandom_range(0, 1) != 0);
                ordy = ($urandom_range(0, 1) != 0);
                id   = (i % 5 == 2) ? c_MN : W'({$urandom(), $urandom()});
                @(posedge clk);
                #1;
            end
            iv   = 1'b0;
            ordy = 1'b1;
            for (int t = 0; t < 100 && qd.size() != 0; t++) @(posedge clk);
            #1;
            check($sformatf("w%0d_drain", W), qd.size(), 0);
            done = 1'b1;
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        vec_t        tbl[9];
        logic [15:0] bp[4];
        logic [15:0] held;
        bit          have;
        int          idx;
        int          seen;
        rec_t        m;

        tbl[0] = '{16'h0005, 16'h0005, 1'b0};
        tbl[1] = '{16'hFFFB, 16'h0005, 1'b0};
        tbl[2] = '{16'h0000, 16'h0000, 1'b0};
        tbl[3] = '{16'h7FFF, 16'h7FFF, 1'b0};
        tbl[4] = '{16'h8000, c_OVF16,  1'b1};
        tbl[5] = '{16'h0001, 16'h0001, 1'b0};
        tbl[6] = '{16'hFFFF, 16'h0001, 1'b0};
        tbl[7] = '{16'h8001, 16'h7FFF, 1'b0};
        tbl[8] = '{16'hC000, 16'h4000, 1'b0};
        bp[0] = 16'h1234; bp[1] = 16'hEDCC; bp[2] = 16'h8000; bp[3] = 16'h0042;

        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_out_valid", {63'd0, out_valid}, 64'd0);
        check("reset_in_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clk);
        #1;

        // Back-to-back stream with latency checks.
        chk_lat = 1'b1;
        for (int i = 0; i < 9; i++) send(tbl[i].din, tbl[i].ed, tbl[i].eo);
        wait_drain();
        chk_lat = 1'b0;

        // Back-pressure: fill the pipe, hold, then pass-through when full.
        out_ready = 1'b0;
        idx = 0; have = 1'b0; held = '0;
        in_valid = 1'b1;
        in_data  = bp[0];
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (out_valid) begin
                if (!have) begin
                    held = out_data;
                    have = 1'b1;
                end else begin
                    check("bp_stable", out_data, held);
                end
            end
            if (in_ready) begin
                m = abs16(bp[idx]);
                push_exp(m.d, m.o);
                idx++;
            end
            @(posedge clk);
            #1 in_data = bp[idx];
        end
        @(negedge clk);
        check("bp_accepted", idx, 2);
        check("bp_in_ready", {63'd0, in_ready}, 64'd0);
        check("bp_out_valid", {63'd0, out_valid}, 64'd1);
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        check("full_pass_ready", {63'd0, in_ready}, 64'd1);
        if (in_ready) begin
            m = abs16(bp[idx]);
            push_exp(m.d, m.o);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        wait_drain();

        // Mid-stream reset with two samples in flight.
        out_ready = 1'b0;
        send(16'h0003, 16'h0003, 1'b0);
        send(16'hFFF0, 16'h0010, 1'b0);
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = 16'h0777;
        @(posedge clk);
        #1 rst = 1'b0;
        in_valid = 1'b0;
        sb.delete();
        @(negedge clk);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        out_ready = 1'b1;
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("rst_dropped", seen, 0);
        @(posedge clk);
        #1;
        send(16'hFFFF, 16'h0001, 1'b0);
        wait_drain();

        for (int t = 0; t < 5000 &&
             !(g_sweep[0].done && g_sweep[1].done && g_sweep[2].done); t++) @(posedge clk);
        check("sweep_done", {61'd0, g_sweep[2].done, g_sweep[1].done, g_sweep[0].done}, 64'd7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
